// File: rtl/target_ctl_pkg.sv
// Shared types and 48 MHz default cycle budgets for the target reset/power/glitch sequencing blocks.
package target_ctl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESET_REQ,
      S_RESET_WAIT,
      S_BOOT_WAIT,
      S_ARMED,
      S_COOLDOWN,
      S_DONE
   } seq_state_t;

   localparam int unsigned CLK_HZ                 = 48_000_000;
   localparam int unsigned BOOT_CYCLES_DEF        = 240_000;
   localparam int unsigned ARM_TIMEOUT_CYCLES_DEF = 4_800_000;
   localparam int unsigned COOLDOWN_CYCLES_DEF    = 48_000;
   localparam int unsigned RESET_WAIT_MAX_DEF     = 960_000;
   localparam int unsigned CNT_W_DEF              = 16;

endpackage

// File: rtl/target_reset_sequencer_seq_timer.sv
// Elapsed-cycle counter: loads 1 on load_i, then counts up (saturating); reached_o when elapsed >= limit_i.
module seq_timer #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] limit_i,
   output logic         reached_o
);

   logic [W-1:0] elapsed_q, elapsed_d;

   always_comb begin
      elapsed_d = elapsed_q;
      if (load_i)
         elapsed_d = W'(1);
      else if (elapsed_q != '1)
         elapsed_d = elapsed_q + W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         elapsed_q <= '0;
      else
         elapsed_q <= elapsed_d;
   end

   assign reached_o = (elapsed_q >= limit_i);

endmodule

// File: rtl/target_reset_sequencer.sv
// Glitch-campaign attempt scheduler: reset target, wait boot, arm glitch, cool down, repeat.
// Optional SEQ_STOP_ON_SUCCESS_EN: stop the campaign when target_ok is seen during COOLDOWN.
module target_reset_sequencer
   import target_ctl_pkg::*;
#(
   parameter int unsigned BOOT_CYCLES        = BOOT_CYCLES_DEF,
   parameter int unsigned ARM_TIMEOUT_CYCLES = ARM_TIMEOUT_CYCLES_DEF,
   parameter int unsigned COOLDOWN_CYCLES    = COOLDOWN_CYCLES_DEF,
   parameter int unsigned RESET_WAIT_MAX     = RESET_WAIT_MAX_DEF,
   parameter int unsigned CNT_W              = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] attempts_cfg,
   output logic             reset_trigger,
   input  logic             reset_busy,
   output logic             glitch_arm,
   input  logic             glitch_fired,
   input  logic             target_ok,
   output logic             busy,
   output logic             done,
   output logic             fault,
   output logic [CNT_W-1:0] attempt_count,
   output logic [CNT_W-1:0] timeout_count
`ifdef SEQ_STOP_ON_SUCCESS_EN
   ,
   output logic             success
`endif
);

   seq_state_t       state_q, state_d;
   logic [CNT_W-1:0] cfg_q, cfg_d;
   logic [CNT_W-1:0] att_q, att_d, att_inc;
   logic [CNT_W-1:0] tmo_q, tmo_d;
   logic             fault_q, fault_d;
   logic             seen_busy_q, seen_busy_d;
   logic             stop_now;
   logic [31:0]      limit;
   logic             load, reached;
`ifdef SEQ_STOP_ON_SUCCESS_EN
   logic             ok_seen_q, ok_seen_d;
   logic             success_q, success_d;
`else
   logic             unused_target_ok;
   assign unused_target_ok = target_ok;
`endif

   assign att_inc = (att_q == '1) ? att_q : att_q + CNT_W'(1);
   assign load    = (state_d != state_q);

   seq_timer #(.W(32)) u_timer (
      .clk       (clk),
      .rst       (rst),
      .load_i    (load),
      .limit_i   (limit),
      .reached_o (reached)
   );

   always_comb begin
      state_d     = state_q;
      cfg_d       = cfg_q;
      att_d       = att_q;
      tmo_d       = tmo_q;
      fault_d     = fault_q;
      seen_busy_d = seen_busy_q;
      stop_now    = (cfg_q != '0) && (att_inc == cfg_q);
      limit       = '1;
`ifdef SEQ_STOP_ON_SUCCESS_EN
      ok_seen_d   = ok_seen_q;
      success_d   = success_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RESET_REQ;
               cfg_d   = attempts_cfg;
               att_d   = '0;
               tmo_d   = '0;
               fault_d = 1'b0;
`ifdef SEQ_STOP_ON_SUCCESS_EN
               success_d = 1'b0;
`endif
            end
         end
         S_RESET_REQ: begin
            state_d     = S_RESET_WAIT;
            seen_busy_d = 1'b0;
         end
         S_RESET_WAIT: begin
            limit = 32'(RESET_WAIT_MAX);
            if (reset_busy)
               seen_busy_d = 1'b1;
            if (seen_busy_q && !reset_busy)
               state_d = S_BOOT_WAIT;
            else if (reached) begin
               state_d = S_IDLE;
               fault_d = 1'b1;
            end
         end
         S_BOOT_WAIT: begin
            limit = 32'(BOOT_CYCLES);
            if (reached)
               state_d = S_ARMED;
         end
         S_ARMED: begin
            limit = 32'(ARM_TIMEOUT_CYCLES);
`ifdef SEQ_STOP_ON_SUCCESS_EN
            ok_seen_d = 1'b0;
`endif
            // A same-cycle glitch_fired wins over the timeout and is not counted as one.
            if (glitch_fired)
               state_d = S_COOLDOWN;
            else if (reached) begin
               state_d = S_COOLDOWN;
               if (tmo_q != '1)
                  tmo_d = tmo_q + CNT_W'(1);
            end
         end
         S_COOLDOWN: begin
            limit = 32'(COOLDOWN_CYCLES);
`ifdef SEQ_STOP_ON_SUCCESS_EN
            if (target_ok)
               ok_seen_d = 1'b1;
            if (ok_seen_q || target_ok) begin
               stop_now = 1'b1;
               if (reached)
                  success_d = 1'b1;
            end
`endif
            if (reached) begin
               att_d   = att_inc;
               state_d = stop_now ? S_DONE : S_RESET_REQ;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Abort freezes all bookkeeping; only the state returns to IDLE.
      if (abort) begin
         state_d = S_IDLE;
         cfg_d   = cfg_q;
         att_d   = att_q;
         tmo_d   = tmo_q;
         fault_d = fault_q;
`ifdef SEQ_STOP_ON_SUCCESS_EN
         success_d = success_q;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cfg_q         <= '0;
         att_q         <= '0;
         tmo_q         <= '0;
         fault_q       <= 1'b0;
         seen_busy_q   <= 1'b0;
         reset_trigger <= 1'b0;
         glitch_arm    <= 1'b0;
         done          <= 1'b0;
         busy          <= 1'b0;
`ifdef SEQ_STOP_ON_SUCCESS_EN
         ok_seen_q     <= 1'b0;
         success_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         cfg_q         <= cfg_d;
         att_q         <= att_d;
         tmo_q         <= tmo_d;
         fault_q       <= fault_d;
         seen_busy_q   <= seen_busy_d;
         reset_trigger <= (state_d == S_RESET_REQ);
         glitch_arm    <= (state_d == S_ARMED);
         done          <= (state_d == S_DONE);
         busy          <= (state_d != S_IDLE);
`ifdef SEQ_STOP_ON_SUCCESS_EN
         ok_seen_q     <= ok_seen_d;
         success_q     <= success_d;
`endif
      end
   end

   assign fault         = fault_q;
   assign attempt_count = att_q;
   assign timeout_count = tmo_q;
`ifdef SEQ_STOP_ON_SUCCESS_EN
   assign success       = success_q;
`endif

endmodule

// File: tb/tb_target_reset_sequencer.sv
// Directed bench for target_reset_sequencer: expected output events are queued at stimulus time
// and checked as the DUT emits them; define SEQ_STOP_ON_SUCCESS_EN to also exercise early stop.
module tb_target_reset_sequencer;

   localparam int EV_NONE = 0;
   localparam int EV_TRIG = 1;
   localparam int EV_ARM  = 2;
   localparam int EV_DONE = 3;

   typedef struct {
      int kind;
      int val;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] attempts_cfg = '0;
   logic        reset_trigger;
   logic        reset_busy = 1'b0;
   logic        glitch_arm;
   logic        glitch_fired;
   logic        gf_model = 1'b0;
   logic        gf_stim = 1'b0;
   logic        target_ok = 1'b0;
   logic        busy;
   logic        done;
   logic        fault;
   logic [15:0] attempt_count;
   logic [15:0] timeout_count;
`ifdef SEQ_STOP_ON_SUCCESS_EN
   logic        success;
`endif

   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  t0 = 0;
   int  arm_len = 0;
   int  g_cnt = 0;
   int  rb_cnt = 0;
   int  rel_idle;
   bit  fire_en = 1'b1;
   bit  busy_stuck_low = 1'b0;
   ev_t exp_q[$];

   assign glitch_fired = gf_model | gf_stim;

   target_reset_sequencer #(
      .BOOT_CYCLES        (5),
      .ARM_TIMEOUT_CYCLES (10),
      .COOLDOWN_CYCLES    (3),
      .RESET_WAIT_MAX     (20),
      .CNT_W              (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .abort         (abort),
      .attempts_cfg  (attempts_cfg),
      .reset_trigger (reset_trigger),
      .reset_busy    (reset_busy),
      .glitch_arm    (glitch_arm),
      .glitch_fired  (glitch_fired),
      .target_ok     (target_ok),
      .busy          (busy),
      .done          (done),
      .fault         (fault),
      .attempt_count (attempt_count),
      .timeout_count (timeout_count)
`ifdef SEQ_STOP_ON_SUCCESS_EN
      ,
      .success       (success)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic expect_ev(input int kind, input int val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int kind, input int val);
      ev_t e;
      if (exp_q.size() == 0) begin
         e.kind = EV_NONE;
         e.val  = 0;
      end else begin
         e = exp_q.pop_front();
      end
      check("event_kind", kind, e.kind);
      check("event_value", val, e.val);
   endtask

   // Reset controller model: busy for 4 cycles starting the cycle after the trigger.
   always @(negedge clk) begin
      reset_busy = (rb_cnt != 0);
      if (rb_cnt != 0) rb_cnt--;
      if (reset_trigger && !busy_stuck_low) rb_cnt = 4;
   end

   // Glitch engine model: fires in the third cycle of ARMED.
   always @(negedge clk) begin
      if (glitch_arm) g_cnt++;
      else g_cnt = 0;
      gf_model = fire_en && glitch_arm && (g_cnt == 3);
   end

   // Output monitor: triggers/done by cycle offset from start, arm windows by length.
   always @(negedge clk) begin
      if (!rst) begin
         if (reset_trigger) observe(EV_TRIG, cyc - t0);
         if (glitch_arm) arm_len++;
         else if (arm_len != 0) begin
            observe(EV_ARM, arm_len);
            arm_len = 0;
         end
         if (done) observe(EV_DONE, cyc - t0);
      end
   end

   task automatic pulse_start(input int cfg);
      attempts_cfg = 16'(cfg);
      start        = 1'b1;
      t0           = cyc;
      @(negedge clk);
      start        = 1'b0;
   endtask

   task automatic wait_idle(input string tag, output int rel);
      int n = 0;
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      rel = cyc - t0;
      check(tag, int'(busy), 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_fault", int'(fault), 0);
      check("rst_arm", int'(glitch_arm), 0);
      check("rst_trigger", int'(reset_trigger), 0);
      check("rst_attempts", int'(attempt_count), 0);
      check("rst_timeouts", int'(timeout_count), 0);
      rst = 1'b0;
      @(negedge clk);

      // Two glitched attempts: 17-cycle attempt period, done after second cooldown.
      expect_ev(EV_TRIG, 1);
      expect_ev(EV_ARM, 3);
      expect_ev(EV_TRIG, 18);
      expect_ev(EV_ARM, 3);
      expect_ev(EV_DONE, 35);
      pulse_start(2);
      wait_idle("t1_idle", rel_idle);
      check("t1_idle_cycle", rel_idle, 36);
      check("t1_attempts", int'(attempt_count), 2);
      check("t1_timeouts", int'(timeout_count), 0);
      check("t1_drained", exp_q.size(), 0);
      @(negedge clk);

      // Single attempt with no glitch: arm timeout after exactly 10 cycles.
      fire_en = 1'b0;
      expect_ev(EV_TRIG, 1);
      expect_ev(EV_ARM, 10);
      expect_ev(EV_DONE, 25);
      pulse_start(1);
      wait_idle("t2_idle", rel_idle);
      check("t2_attempts", int'(attempt_count), 1);
      check("t2_timeouts", int'(timeout_count), 1);
      check("t2_drained", exp_q.size(), 0);
      fire_en = 1'b1;
      @(negedge clk);

      // reset_busy never rises: fault after 20 cycles of RESET_WAIT, no arm, no done.
      busy_stuck_low = 1'b1;
      expect_ev(EV_TRIG, 1);
      pulse_start(1);
      wait_idle("t3_idle", rel_idle);
      check("t3_idle_cycle", rel_idle, 22);
      check("t3_fault", int'(fault), 1);
      check("t3_attempts", int'(attempt_count), 0);
      check("t3_drained", exp_q.size(), 0);
      busy_stuck_low = 1'b0;
      @(negedge clk);

      // Unlimited campaign aborted during BOOT_WAIT of attempt 3; start clears fault.
      expect_ev(EV_TRIG, 1);
      expect_ev(EV_ARM, 3);
      expect_ev(EV_TRIG, 18);
      expect_ev(EV_ARM, 3);
      expect_ev(EV_TRIG, 35);
      pulse_start(0);
      check("t4_fault_cleared", int'(fault), 0);
      repeat (41) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t4_busy", int'(busy), 0);
      check("t4_arm", int'(glitch_arm), 0);
      check("t4_attempts", int'(attempt_count), 2);
      repeat (5) @(negedge clk);
      check("t4_drained", exp_q.size(), 0);

      // Stray start and glitch_fired during BOOT_WAIT leave timing unchanged.
      expect_ev(EV_TRIG, 1);
      expect_ev(EV_ARM, 3);
      expect_ev(EV_DONE, 18);
      pulse_start(1);
      repeat (7) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      gf_stim = 1'b1;
      @(negedge clk);
      gf_stim = 1'b0;
      wait_idle("t5_idle", rel_idle);
      check("t5_idle_cycle", rel_idle, 19);
      check("t5_attempts", int'(attempt_count), 1);
      check("t5_drained", exp_q.size(), 0);
      @(negedge clk);

`ifdef SEQ_STOP_ON_SUCCESS_EN
      // target_ok in the second cooldown ends a 5-attempt campaign early.
      expect_ev(EV_TRIG, 1);
      expect_ev(EV_ARM, 3);
      expect_ev(EV_TRIG, 18);
      expect_ev(EV_ARM, 3);
      expect_ev(EV_DONE, 35);
      pulse_start(5);
      check("t6_success_clear", int'(success), 0);
      repeat (32) @(negedge clk);
      target_ok = 1'b1;
      @(negedge clk);
      target_ok = 1'b0;
      wait_idle("t6_idle", rel_idle);
      check("t6_success", int'(success), 1);
      check("t6_attempts", int'(attempt_count), 2);
      check("t6_drained", exp_q.size(), 0);
      @(negedge clk);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
